hc_result_reporter: RTL

- Consumer of the hill-climbing optimizer's result.
- Detects the rising edge of the optimizer's done flag and snapshots best_fitness / best_solution.
- Serializes the snapshot as a framed byte stream over a valid/ready interface, toward a UART/host link.
- Sits between the optimizer core and the byte transport; keeps the solver free to restart while the report drains.

---
 rtl/hc_pkg.sv | 22 ++
 rtl/hc_result_reporter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hc_pkg.sv
// Shared types and constants for the hill-climbing result reporter.
// Holds the frame state encoding and the fitness high-byte helper.
package hc_pkg;

    localparam int         FIT_W            = 12;
    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FIT_HI,
        FIT_LO,
        SOL,
        CHK
    } rep_state_t;

    // Upper fitness nibble, zero-padded so it travels as one byte.
    function automatic logic [7:0] fit_hi_byte(input logic [FIT_W-1:0] fit);
        return {4'b0000, fit[FIT_W-1:8]};
    endfunction

endpackage

// File: rtl/hc_result_reporter.sv
// Snapshots the optimizer result on a rising done edge and streams it as a
// framed byte sequence (header, fitness, solution LSB-first, XOR checksum).
module hc_result_reporter
    import hc_pkg::*;
#(
    parameter int         N_BITS   = 1024,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done_i,
    input  logic [FIT_W-1:0]  best_fitness_i,
    input  logic [N_BITS-1:0] best_solution_i,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count
);

    localparam int N_BYTES = N_BITS / 8;
    localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    if ((N_BITS % 8) != 0 || N_BITS < 8) begin : g_bad_width
        $error("hc_result_reporter: N_BITS must be a multiple of 8 and at least 8");
    end

    rep_state_t        state, state_n;
    logic              done_q;
    logic [FIT_W-1:0]  fit_r, fit_n;
    logic [N_BITS-1:0] sol_r, sol_n;
    logic [7:0]        chk, chk_n;
    logic [IDX_W-1:0]  idx, idx_n, idx_inc;
    logic [7:0]        data_n;
    logic              valid_n;
    logic              busy_n;
    logic              frame_done_n;
    logic [15:0]       count_n;
    logic              trig;
    logic              accept;

    assign trig    = done_i & ~done_q;
    assign accept  = tx_valid & tx_ready;
    assign idx_inc = idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            fit_r       <= '0;
            sol_r       <= '0;
            chk         <= 8'h00;
            idx         <= '0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            state       <= state_n;
            done_q      <= done_i;
            fit_r       <= fit_n;
            sol_r       <= sol_n;
            chk         <= chk_n;
            idx         <= idx_n;
            tx_data     <= data_n;
            tx_valid    <= valid_n;
            busy        <= busy_n;
            frame_done  <= frame_done_n;
            frame_count <= count_n;
        end
    end

    // Every output is computed here and registered, so tx_ready never reaches
    // tx_valid/tx_data combinationally; the next byte is staged on the handshake.
    always_comb begin
        state_n      = state;
        fit_n        = fit_r;
        sol_n        = sol_r;
        chk_n        = chk;
        idx_n        = idx;
        data_n       = tx_data;
        valid_n      = tx_valid;
        busy_n       = busy;
        frame_done_n = 1'b0;
        count_n      = frame_count;

        case (state)
            IDLE: begin
                if (trig) begin
                    fit_n   = best_fitness_i;
                    sol_n   = best_solution_i;
                    chk_n   = 8'h00;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    valid_n = 1'b1;
                    data_n  = HDR_BYTE;
                    state_n = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    data_n  = fit_hi_byte(fit_r);
                    state_n = FIT_HI;
                end
            end
            FIT_HI: begin
                if (accept) begin
                    chk_n   = chk ^ tx_data;
                    data_n  = fit_r[7:0];
                    state_n = FIT_LO;
                end
            end
            FIT_LO: begin
                if (accept) begin
                    chk_n   = chk ^ tx_data;
                    data_n  = sol_r[7:0];
                    idx_n   = '0;
                    state_n = SOL;
                end
            end
            SOL: begin
                if (accept) begin
                    chk_n = chk ^ tx_data;
                    if (idx == LAST_IDX) begin
                        data_n  = chk ^ tx_data;
                        state_n = CHK;
                    end else begin
                        idx_n  = idx_inc;
                        data_n = sol_r[{idx_inc, 3'b000} +: 8];
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    valid_n      = 1'b0;
                    busy_n       = 1'b0;
                    frame_done_n = 1'b1;
                    count_n      = frame_count + 16'd1;
                    data_n       = 8'h00;
                    idx_n        = '0;
                    state_n      = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
